hook_swing_controller: RTL and testbench
========================================

// Module: hook_swing_controller
// PURPOSE
//  Sequences the hook: swings the rope angle per frame, launches and extends the rope on fire,
//  retracts it (load-dependent speed), then resumes swinging. Drives alpha into the 0-90 deg
//  sine/cosine LUT and turns LUT dx/dy (scale 1023) plus rope length into screen hook coordinates.
//  Sits between the player input/collision logic and the rope/hook drawing objects.
// PARAMETERS
//  PIVOT_X        320  rope pivot X (pixels)
//  PIVOT_Y         40  rope pivot Y (pixels)
//  MIN_ANG         10  lowest swing angle (deg, 0=right, 90=down, 180=left)
//  MAX_ANG        170  highest swing angle (deg)
//  SWING_STEP       2  deg added/subtracted per frame while swinging
//  MIN_LEN         20  rest rope length (pixels)
//  MAX_LEN        450  max rope length (pixels, <512)
//  EXTEND_SPEED     6  pixels/frame while extending
//  RETRACT_SPEED    8  pixels/frame while retracting, empty hook
// PORTS
//  clk            in   1   system clock
//  reset          in   1   async, active-high reset
//  startOfFrame   in   1   1-cycle tick, once per video frame
//  fire           in   1   1-cycle launch request
//  grabbed        in   1   hook collided with an item (level, sampled on startOfFrame)
//  out_of_bounds  in   1   hook left the playfield (level, sampled on startOfFrame)
//  weight         in   3   load of grabbed item, 0=light .. 7=heavy
//  lut_dx         in   10  cosine from LUT, 0..1023
//  lut_dy         in   10  sine from LUT, 0..1023
//  lut_alpha      out  7   LUT angle 0..90 (LUT shift_radius tied to 0 by integrator)
//  hookX          out  11  signed hook X (pixels)
//  hookY          out  11  signed hook Y (pixels)
//  rope_len       out  9   current rope length
//  busy           out  1   1 in EXTEND or RETRACT
//  loaded         out  1   item attached (set on grab, cleared on delivery)
//  delivered      out  1   1-cycle pulse when a loaded hook returns to MIN_LEN
// BEHAVIOUR
//  Reset: state=SWING, ang=90, dir=+1, rope_len=MIN_LEN, loaded=0, delivered=0, busy=0,
//   hookX=PIVOT_X, hookY=PIVOT_Y; all registers async-cleared.
//  lut_alpha combinational: ang<=90 ? ang : 180-ang. LUT combinational.
//  Position registered every clk (1-cycle latency after ang/len): offX=(rope_len*lut_dx)>>10,
//   offY=(rope_len*lut_dy)>>10 (19-bit product); hookX=PIVOT_X+offX if ang<=90 else PIVOT_X-offX;
//   hookY=PIVOT_Y+offY.
//  SWING: on startOfFrame ang+=dir*SWING_STEP; if result >=MAX_ANG clamp to MAX_ANG, dir=-1;
//   if <=MIN_ANG clamp to MIN_ANG, dir=+1. fire -> EXTEND next clk, busy=1.
//   fire and startOfFrame same cycle: fire wins, no ang update.
//  EXTEND: ang frozen. On startOfFrame: if grabbed -> loaded=1, RETRACT (no length change);
//   else if out_of_bounds or rope_len+EXTEND_SPEED>=MAX_LEN -> rope_len=min(len+step,MAX_LEN),
//   RETRACT; else rope_len+=EXTEND_SPEED. grabbed has priority over out_of_bounds.
//  RETRACT: on startOfFrame step = loaded ? max(1, RETRACT_SPEED>>weight) : RETRACT_SPEED;
//   if rope_len-step<=MIN_LEN -> rope_len=MIN_LEN, SWING, busy=0, delivered pulses 1 clk iff
//   loaded, loaded=0 same cycle; else rope_len-=step. weight sampled each frame.
//  fire outside SWING ignored (no queuing). grabbed/out_of_bounds ignored outside EXTEND.
//  No underflow: rope_len never leaves [MIN_LEN,MAX_LEN]; ang never leaves [MIN_ANG,MAX_ANG].
//  Reset mid-EXTEND/RETRACT: immediate return to reset values; loaded item dropped, no delivered.
// CONFIGURATION
//  HOOK_SWING_PAUSE_EN defined: extra input `pause` (1 bit); while 1 all state, ang, rope_len,
//   loaded hold, startOfFrame and fire ignored, delivered held 0; hookX/Y still recomputed.
//  Not defined: no pause port; controller always runs.
// TESTING
//  reset, 45 frames in SWING -> ang 90->170 (frame 40), then decreasing, hookX<PIVOT_X after ang>90.
//  ang=90, fire, 5 frames -> rope_len=50, hookX=320, hookY=40+(50*1023>>10)=89.
//  EXTEND at len=50, grabbed=1 weight=2 -> RETRACT, steps of 2/frame, 15 frames to 20, delivered 1 clk.
//  EXTEND no hit -> len reaches 450 (clamped), RETRACT 8/frame, back to SWING, delivered stays 0.
//  fire+startOfFrame same cycle in SWING -> EXTEND, ang unchanged; fire during RETRACT ignored.
//  reset asserted mid-RETRACT loaded -> all outputs to reset values same cycle, no delivered pulse.

Source files
------------

// File: rtl/hook_swing_controller.sv
// Hook sequencer: swings the rope angle, extends on fire, retracts with load-dependent speed,
// and converts LUT dx/dy plus rope length to hook coordinates. Optional: HOOK_SWING_PAUSE_EN.
module hook_swing_controller #(
    parameter int PIVOT_X       = 320,
    parameter int PIVOT_Y       = 40,
    parameter int MIN_ANG       = 10,
    parameter int MAX_ANG       = 170,
    parameter int SWING_STEP    = 2,
    parameter int MIN_LEN       = 20,
    parameter int MAX_LEN       = 450,
    parameter int EXTEND_SPEED  = 6,
    parameter int RETRACT_SPEED = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               fire,
`ifdef HOOK_SWING_PAUSE_EN
    input  logic               pause,
`endif
    input  logic               grabbed,
    input  logic               out_of_bounds,
    input  logic [2:0]         weight,
    input  logic [9:0]         lut_dx,
    input  logic [9:0]         lut_dy,
    output logic [6:0]         lut_alpha,
    output logic signed [10:0] hookX,
    output logic signed [10:0] hookY,
    output logic [8:0]         rope_len,
    output logic               busy,
    output logic               loaded,
    output logic               delivered
);

    localparam logic [1:0] ST_SWING   = 2'd0;
    localparam logic [1:0] ST_EXTEND  = 2'd1;
    localparam logic [1:0] ST_RETRACT = 2'd2;

    logic [1:0]         r_state;
    logic [7:0]         r_ang;
    logic               r_dir;
    logic [8:0]         r_len;
    logic               r_loaded;
    logic               r_delivered;
    logic signed [10:0] r_hook_x;
    logic signed [10:0] r_hook_y;

    logic [1:0] w_state_nxt;
    logic [7:0] w_ang_nxt;
    logic       w_dir_nxt;
    logic [8:0] w_len_nxt;
    logic       w_loaded_nxt;
    logic       w_delivered_nxt;
    logic       w_run;
    logic [7:0] w_ang_up;
    logic [7:0] w_ang_dn;
    logic [9:0] w_len_ext;
    logic [8:0] w_ret_shift;
    logic [8:0] w_step;
    logic [8:0] w_off_x;
    logic [8:0] w_off_y;

`ifdef HOOK_SWING_PAUSE_EN
    assign w_run = ~pause;
`else
    assign w_run = 1'b1;
`endif

    assign w_ang_up    = r_ang + 8'(SWING_STEP);
    assign w_ang_dn    = r_ang - 8'(SWING_STEP);
    assign w_len_ext   = {1'b0, r_len} + 10'(EXTEND_SPEED);
    assign w_ret_shift = 9'(RETRACT_SPEED) >> weight;
    // Heavy loads never stall: the shifted speed bottoms out at 1 pixel/frame.
    assign w_step      = !r_loaded ? 9'(RETRACT_SPEED) :
                         (w_ret_shift == 9'd0) ? 9'd1 : w_ret_shift;

    always_comb begin
        w_state_nxt     = r_state;
        w_ang_nxt       = r_ang;
        w_dir_nxt       = r_dir;
        w_len_nxt       = r_len;
        w_loaded_nxt    = r_loaded;
        w_delivered_nxt = 1'b0;
        if (w_run) begin
            case (r_state)
                ST_SWING: begin
                    if (fire) begin
                        w_state_nxt = ST_EXTEND;
                    end else if (startOfFrame) begin
                        if (r_dir) begin
                            if (w_ang_up >= 8'(MAX_ANG)) begin
                                w_ang_nxt = 8'(MAX_ANG);
                                w_dir_nxt = 1'b0;
                            end else begin
                                w_ang_nxt = w_ang_up;
                            end
                        end else if (w_ang_dn <= 8'(MIN_ANG)) begin
                            w_ang_nxt = 8'(MIN_ANG);
                            w_dir_nxt = 1'b1;
                        end else begin
                            w_ang_nxt = w_ang_dn;
                        end
                    end
                end
                ST_EXTEND: begin
                    if (startOfFrame) begin
                        if (grabbed) begin
                            w_loaded_nxt = 1'b1;
                            w_state_nxt  = ST_RETRACT;
                        end else if (out_of_bounds || (w_len_ext >= 10'(MAX_LEN))) begin
                            w_len_nxt   = (w_len_ext >= 10'(MAX_LEN)) ? 9'(MAX_LEN)
                                                                      : w_len_ext[8:0];
                            w_state_nxt = ST_RETRACT;
                        end else begin
                            w_len_nxt = w_len_ext[8:0];
                        end
                    end
                end
                ST_RETRACT: begin
                    if (startOfFrame) begin
                        // Compared as len <= MIN+step so the subtraction never wraps.
                        if ({1'b0, r_len} <= (10'(MIN_LEN) + {1'b0, w_step})) begin
                            w_len_nxt       = 9'(MIN_LEN);
                            w_state_nxt     = ST_SWING;
                            w_delivered_nxt = r_loaded;
                            w_loaded_nxt    = 1'b0;
                        end else begin
                            w_len_nxt = r_len - w_step;
                        end
                    end
                end
                default: w_state_nxt = ST_SWING;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_SWING;
            r_ang       <= 8'd90;
            r_dir       <= 1'b1;
            r_len       <= 9'(MIN_LEN);
            r_loaded    <= 1'b0;
            r_delivered <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ang       <= w_ang_nxt;
            r_dir       <= w_dir_nxt;
            r_len       <= w_len_nxt;
            r_loaded    <= w_loaded_nxt;
            r_delivered <= w_delivered_nxt;
        end
    end

    assign w_off_x = 9'((19'(r_len) * 19'(lut_dx)) >> 10);
    assign w_off_y = 9'((19'(r_len) * 19'(lut_dy)) >> 10);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hook_x <= 11'(PIVOT_X);
            r_hook_y <= 11'(PIVOT_Y);
        end else begin
            r_hook_x <= (r_ang <= 8'd90) ? 11'(PIVOT_X) + {2'b00, w_off_x}
                                         : 11'(PIVOT_X) - {2'b00, w_off_x};
            r_hook_y <= 11'(PIVOT_Y) + {2'b00, w_off_y};
        end
    end

    assign lut_alpha = (r_ang <= 8'd90) ? r_ang[6:0] : 7'(8'd180 - r_ang);
    assign hookX     = r_hook_x;
    assign hookY     = r_hook_y;
    assign rope_len  = r_len;
    assign busy      = (r_state != ST_SWING);
    assign loaded    = r_loaded;
    assign delivered = r_delivered;

endmodule

// File: tb/tb_hook_swing_controller.sv
// Directed bench for hook_swing_controller; drives a simple linear sine/cosine table.
module tb_hook_swing_controller;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               startOfFrame = 1'b0;
    logic               fire = 1'b0;
    logic               grabbed = 1'b0;
    logic               out_of_bounds = 1'b0;
    logic [2:0]         weight = 3'd0;
    logic [9:0]         lut_dx;
    logic [9:0]         lut_dy;
    logic [6:0]         lut_alpha;
    logic signed [10:0] hookX;
    logic signed [10:0] hookY;
    logic [8:0]         rope_len;
    logic               busy;
    logic               loaded;
    logic               delivered;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Stand-in LUT: exact at 90 deg, linear elsewhere.
    always_comb begin
        lut_dx = 10'((7'd90 - lut_alpha) * 11);
        lut_dy = (lut_alpha == 7'd90) ? 10'd1023 : 10'(lut_alpha * 11);
    end

    hook_swing_controller dut (
        .clk           (clk),
        .reset         (reset),
        .startOfFrame  (startOfFrame),
        .fire          (fire),
        .grabbed       (grabbed),
        .out_of_bounds (out_of_bounds),
        .weight        (weight),
        .lut_dx        (lut_dx),
        .lut_dy        (lut_dy),
        .lut_alpha     (lut_alpha),
        .hookX         (hookX),
        .hookY         (hookY),
        .rope_len      (rope_len),
        .busy          (busy),
        .loaded        (loaded),
        .delivered     (delivered)
    );

    task automatic tick(input logic sof, input logic f);
        @(negedge clk);
        startOfFrame = sof;
        fire = f;
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        fire = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({rope_len, busy, loaded, delivered, lut_alpha} !== {9'd20, 3'b000, 7'd90}) begin
            n_fail++;
            $display("FAIL reset_state: len=%0d busy=%b loaded=%b dlv=%b alpha=%0d, want 20 0 0 0 90",
                     rope_len, busy, loaded, delivered, lut_alpha);
        end
        n_tests++;
        if (hookX !== 11'sd320 || hookY !== 11'sd40) begin
            n_fail++;
            $display("FAIL reset_hook: x=%0d y=%0d, want 320 40", hookX, hookY);
        end
        @(negedge clk);
        reset = 1'b0;
        tick(1'b0, 1'b0);
        n_tests++;
        if (hookX !== 11'sd320 || hookY !== 11'sd59) begin
            n_fail++;
            $display("FAIL rest_hook: x=%0d y=%0d, want 320 59", hookX, hookY);
        end
    endtask

    task automatic test_swing;
        frames(1);
        n_tests++;
        if (lut_alpha !== 7'd88) begin
            n_fail++;
            $display("FAIL swing_first: alpha=%0d, want 88", lut_alpha);
        end
        frames(39);
        n_tests++;
        if (lut_alpha !== 7'd10 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL swing_max: alpha=%0d busy=%b, want 10 0", lut_alpha, busy);
        end
        tick(1'b0, 1'b0);
        n_tests++;
        if (hookX !== 11'sd303 || hookY !== 11'sd42) begin
            n_fail++;
            $display("FAIL swing_max_hook: x=%0d y=%0d, want 303 42", hookX, hookY);
        end
        frames(5);
        tick(1'b0, 1'b0);
        n_tests++;
        if (lut_alpha !== 7'd20 || hookX !== 11'sd305) begin
            n_fail++;
            $display("FAIL swing_back: alpha=%0d x=%0d, want 20 305", lut_alpha, hookX);
        end
        frames(35);
        n_tests++;
        if (lut_alpha !== 7'd90) begin
            n_fail++;
            $display("FAIL swing_return: alpha=%0d, want 90", lut_alpha);
        end
    endtask

    task automatic test_extend_grab;
        tick(1'b0, 1'b1);
        n_tests++;
        if (busy !== 1'b1 || rope_len !== 9'd20) begin
            n_fail++;
            $display("FAIL fire_start: busy=%b len=%0d, want 1 20", busy, rope_len);
        end
        frames(5);
        tick(1'b0, 1'b0);
        n_tests++;
        if (rope_len !== 9'd50 || lut_alpha !== 7'd90 || hookX !== 11'sd320 || hookY !== 11'sd89) begin
            n_fail++;
            $display("FAIL extend_50: len=%0d alpha=%0d x=%0d y=%0d, want 50 90 320 89",
                     rope_len, lut_alpha, hookX, hookY);
        end
        grabbed = 1'b1;
        weight = 3'd2;
        tick(1'b1, 1'b0);
        grabbed = 1'b0;
        n_tests++;
        if (loaded !== 1'b1 || rope_len !== 9'd50 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL grab: loaded=%b len=%0d busy=%b, want 1 50 1", loaded, rope_len, busy);
        end
        frames(7);
        tick(1'b0, 1'b1);
        n_tests++;
        if (rope_len !== 9'd36 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL fire_in_retract: len=%0d busy=%b, want 36 1", rope_len, busy);
        end
        frames(7);
        n_tests++;
        if (rope_len !== 9'd22 || delivered !== 1'b0) begin
            n_fail++;
            $display("FAIL retract_22: len=%0d dlv=%b, want 22 0", rope_len, delivered);
        end
        frames(1);
        n_tests++;
        if ({rope_len, delivered, loaded, busy} !== {9'd20, 3'b100}) begin
            n_fail++;
            $display("FAIL deliver: len=%0d dlv=%b loaded=%b busy=%b, want 20 1 0 0",
                     rope_len, delivered, loaded, busy);
        end
        tick(1'b0, 1'b0);
        n_tests++;
        if (delivered !== 1'b0) begin
            n_fail++;
            $display("FAIL deliver_pulse: dlv=%b, want 0", delivered);
        end
    endtask

    task automatic test_extend_max;
        tick(1'b0, 1'b1);
        frames(71);
        n_tests++;
        if (rope_len !== 9'd446 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL extend_446: len=%0d busy=%b, want 446 1", rope_len, busy);
        end
        frames(1);
        tick(1'b0, 1'b0);
        n_tests++;
        if (rope_len !== 9'd450 || hookX !== 11'sd320 || hookY !== 11'sd489) begin
            n_fail++;
            $display("FAIL extend_clamp: len=%0d x=%0d y=%0d, want 450 320 489",
                     rope_len, hookX, hookY);
        end
        for (int i = 0; i < 53; i++) begin
            tick(1'b1, 1'b0);
            n_tests++;
            if (delivered !== 1'b0) begin
                n_fail++;
                $display("FAIL empty_no_dlv: frame %0d dlv=%b, want 0", i, delivered);
            end
        end
        n_tests++;
        if (rope_len !== 9'd26 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL retract_26: len=%0d busy=%b, want 26 1", rope_len, busy);
        end
        frames(1);
        n_tests++;
        if ({rope_len, busy, delivered} !== {9'd20, 2'b00}) begin
            n_fail++;
            $display("FAIL empty_home: len=%0d busy=%b dlv=%b, want 20 0 0",
                     rope_len, busy, delivered);
        end
    endtask

    task automatic test_fire_sof;
        tick(1'b1, 1'b1);
        n_tests++;
        if (busy !== 1'b1 || lut_alpha !== 7'd90) begin
            n_fail++;
            $display("FAIL fire_sof: busy=%b alpha=%0d, want 1 90", busy, lut_alpha);
        end
        out_of_bounds = 1'b1;
        tick(1'b1, 1'b0);
        out_of_bounds = 1'b0;
        n_tests++;
        if ({rope_len, busy, loaded} !== {9'd26, 2'b10}) begin
            n_fail++;
            $display("FAIL oob: len=%0d busy=%b loaded=%b, want 26 1 0", rope_len, busy, loaded);
        end
        frames(1);
        n_tests++;
        if ({rope_len, busy, delivered} !== {9'd20, 2'b00} || lut_alpha !== 7'd90) begin
            n_fail++;
            $display("FAIL oob_home: len=%0d busy=%b dlv=%b alpha=%0d, want 20 0 0 90",
                     rope_len, busy, delivered, lut_alpha);
        end
        tick(1'b0, 1'b1);
        grabbed = 1'b1;
        out_of_bounds = 1'b1;
        weight = 3'd7;
        tick(1'b1, 1'b0);
        grabbed = 1'b0;
        out_of_bounds = 1'b0;
        n_tests++;
        if (loaded !== 1'b1 || rope_len !== 9'd20) begin
            n_fail++;
            $display("FAIL grab_priority: loaded=%b len=%0d, want 1 20", loaded, rope_len);
        end
        frames(1);
        n_tests++;
        if ({rope_len, delivered, busy, loaded} !== {9'd20, 3'b100}) begin
            n_fail++;
            $display("FAIL heavy_deliver: len=%0d dlv=%b busy=%b loaded=%b, want 20 1 0 0",
                     rope_len, delivered, busy, loaded);
        end
    endtask

    task automatic test_reset_mid;
        tick(1'b0, 1'b1);
        frames(5);
        grabbed = 1'b1;
        weight = 3'd0;
        tick(1'b1, 1'b0);
        grabbed = 1'b0;
        frames(2);
        n_tests++;
        if (loaded !== 1'b1 || rope_len !== 9'd34) begin
            n_fail++;
            $display("FAIL pre_reset: loaded=%b len=%0d, want 1 34", loaded, rope_len);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_tests++;
        if ({rope_len, busy, loaded, delivered, lut_alpha} !== {9'd20, 3'b000, 7'd90} ||
            hookX !== 11'sd320 || hookY !== 11'sd40) begin
            n_fail++;
            $display("FAIL mid_reset: len=%0d busy=%b loaded=%b dlv=%b alpha=%0d x=%0d y=%0d",
                     rope_len, busy, loaded, delivered, lut_alpha, hookX, hookY);
        end
        @(negedge clk);
        reset = 1'b0;
        tick(1'b0, 1'b0);
        n_tests++;
        if ({delivered, loaded, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL post_reset: dlv=%b loaded=%b busy=%b, want 0 0 0",
                     delivered, loaded, busy);
        end
        frames(1);
        n_tests++;
        if (lut_alpha !== 7'd88) begin
            n_fail++;
            $display("FAIL post_reset_dir: alpha=%0d, want 88", lut_alpha);
        end
    endtask

    initial begin
        test_reset();
        test_swing();
        test_extend_grab();
        test_extend_max();
        test_fire_sof();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
